spi_xfer_sched: RTL and testbench

// - Wishbone-master scheduler that shares one SPI master core (WB slave) between NREQ requesters.
// - Round-robin grants one transfer at a time, then programs DIVIDER/SS/TX0/CTRL(GO) on the core.
// - Waits for completion, reads RX0 and returns it tagged with the requester id.
// - Sits between client logic and the SPI core's WB port; the core's wb_int_o feeds m_int_i.

---
 rtl/spi_xfer_sched_if.sv | 23 ++
 rtl/spi_xfer_sched.sv | 178 +++++++++++++++++
 tb/tb_spi_xfer_sched.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_xfer_sched_if.sv
// Wishbone master bus between spi_xfer_sched and the SPI master core, plus the core's
// transfer-done interrupt.
interface spi_xfer_sched_if;
    logic [4:0]  m_adr_o;
    logic [31:0] m_dat_o;
    logic [31:0] m_dat_i;
    logic [3:0]  m_sel_o;
    logic        m_we_o;
    logic        m_stb_o;
    logic        m_cyc_o;
    logic        m_ack_i;
    logic        m_int_i;

    modport master (
        output m_adr_o, m_dat_o, m_sel_o, m_we_o, m_stb_o, m_cyc_o,
        input  m_dat_i, m_ack_i, m_int_i
    );

    modport slave (
        input  m_adr_o, m_dat_o, m_sel_o, m_we_o, m_stb_o, m_cyc_o,
        output m_dat_i, m_ack_i, m_int_i
    );
endinterface

// File: rtl/spi_xfer_sched.sv
// Round-robin scheduler sharing one Wishbone SPI master core between NREQ requesters.
// Define SPI_SCHED_POLL_EN to poll CTRL.GO for completion instead of waiting on m_int_i.
module spi_xfer_sched #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned SS_NB = 8,
    parameter int unsigned DIV_W = 16
) (
    input  logic                    wb_clk_in,
    input  logic                    wb_rst_in,
    input  logic [NREQ-1:0]         req_i,
    input  logic [NREQ*32-1:0]      req_tx_i,
    input  logic [NREQ*7-1:0]       req_len_i,
    input  logic [NREQ*SS_NB-1:0]   req_ss_i,
    input  logic [DIV_W-1:0]        cfg_div_i,
    input  logic [2:0]              cfg_mode_i,
    output logic [NREQ-1:0]         gnt_o,
    output logic                    busy_o,
    output logic                    rsp_valid_o,
    output logic [2:0]              rsp_id_o,
    output logic [31:0]             rsp_data_o,
    spi_xfer_sched_if.master        wb
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WR_DIV  = 3'd1;
    localparam logic [2:0] ST_WR_SS   = 3'd2;
    localparam logic [2:0] ST_WR_TX   = 3'd3;
    localparam logic [2:0] ST_WR_CTRL = 3'd4;
    localparam logic [2:0] ST_WAIT    = 3'd5;
    localparam logic [2:0] ST_RD_RX   = 3'd6;
    localparam logic [2:0] ST_RESP    = 3'd7;

    localparam logic [4:0] ADR_DATA = 5'h00;
    localparam logic [4:0] ADR_CTRL = 5'h10;
    localparam logic [4:0] ADR_DIV  = 5'h14;
    localparam logic [4:0] ADR_SS   = 5'h18;

`ifdef SPI_SCHED_POLL_EN
    localparam logic CTRL_IE = 1'b0;
`else
    localparam logic CTRL_IE = 1'b1;
`endif

    logic [2:0]       state_q, state_d;
    logic             gap_q;
    logic [2:0]       ptr_q, cur_id_q;
    logic [31:0]      tx_q;
    logic [6:0]       len_q;
    logic [SS_NB-1:0] ss_q;
    logic             div_valid_q;
    logic [DIV_W-1:0] div_last_q;
    logic [2:0]       rsp_id_q;
    logic [31:0]      rsp_data_q;

    logic             found;
    logic [2:0]       win_id, win_next;
    int               idx;

    // First asserted request at or after the pointer, wrapping.
    always_comb begin
        found  = 1'b0;
        win_id = '0;
        idx    = 0;
        for (int k = 0; k < int'(NREQ); k++) begin
            idx = (int'(ptr_q) + k) % int'(NREQ);
            if (!found && req_i[idx]) begin
                found  = 1'b1;
                win_id = 3'(idx);
            end
        end
        win_next = 3'((int'(win_id) + 1) % int'(NREQ));
    end

    logic need_div;
    assign need_div = !div_valid_q || (cfg_div_i != div_last_q);

    logic        acc, acc_we, stb, ack;
    logic [4:0]  acc_adr;
    logic [31:0] acc_dat, div_ext, ss_ext, ctrl_word;

    always_comb begin
        div_ext = '0;
        div_ext[DIV_W-1:0] = cfg_div_i;
        ss_ext = '0;
        ss_ext[SS_NB-1:0] = ss_q;
        // {ASS, IE, lsb, tx_neg, rx_neg, GO, 0, len}
        ctrl_word = {18'd0, 1'b1, CTRL_IE, cfg_mode_i, 1'b1, 1'b0, len_q};
        acc     = 1'b0;
        acc_we  = 1'b0;
        acc_adr = ADR_DATA;
        acc_dat = '0;
        case (state_q)
            ST_WR_DIV:  begin acc = 1'b1; acc_we = 1'b1; acc_adr = ADR_DIV;  acc_dat = div_ext;   end
            ST_WR_SS:   begin acc = 1'b1; acc_we = 1'b1; acc_adr = ADR_SS;   acc_dat = ss_ext;    end
            ST_WR_TX:   begin acc = 1'b1; acc_we = 1'b1; acc_adr = ADR_DATA; acc_dat = tx_q;      end
            ST_WR_CTRL: begin acc = 1'b1; acc_we = 1'b1; acc_adr = ADR_CTRL; acc_dat = ctrl_word; end
`ifdef SPI_SCHED_POLL_EN
            ST_WAIT:    begin acc = 1'b1; acc_adr = ADR_CTRL; end
`endif
            ST_RD_RX:   acc = 1'b1;
            default:    ;
        endcase
    end

    // gap_q forces one idle bus cycle after every ack.
    assign stb        = acc && !gap_q;
    assign ack        = stb && wb.m_ack_i;
    assign wb.m_cyc_o = stb;
    assign wb.m_stb_o = stb;
    assign wb.m_we_o  = stb && acc_we;
    assign wb.m_adr_o = stb ? acc_adr : 5'h00;
    assign wb.m_dat_o = stb ? acc_dat : 32'h0;
    assign wb.m_sel_o = stb ? 4'hF : 4'h0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (found) state_d = need_div ? ST_WR_DIV : ST_WR_SS;
            ST_WR_DIV:  if (ack) state_d = ST_WR_SS;
            ST_WR_SS:   if (ack) state_d = ST_WR_TX;
            ST_WR_TX:   if (ack) state_d = ST_WR_CTRL;
            ST_WR_CTRL: if (ack) state_d = ST_WAIT;
`ifdef SPI_SCHED_POLL_EN
            ST_WAIT:    if (ack && !wb.m_dat_i[8]) state_d = ST_RD_RX;
`else
            ST_WAIT:    if (wb.m_int_i) state_d = ST_RD_RX;
`endif
            ST_RD_RX:   if (ack) state_d = ST_RESP;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_in or posedge wb_rst_in) begin
        if (wb_rst_in) begin
            state_q     <= ST_IDLE;
            gap_q       <= 1'b0;
            ptr_q       <= '0;
            cur_id_q    <= '0;
            tx_q        <= '0;
            len_q       <= '0;
            ss_q        <= '0;
            div_valid_q <= 1'b0;
            div_last_q  <= '0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
        end else begin
            state_q <= state_d;
            gap_q   <= ack;
            if (state_q == ST_IDLE && found) begin
                ptr_q    <= win_next;
                cur_id_q <= win_id;
                tx_q     <= req_tx_i[32*int'(win_id) +: 32];
                len_q    <= req_len_i[7*int'(win_id) +: 7];
                ss_q     <= req_ss_i[SS_NB*int'(win_id) +: SS_NB];
            end
            if (state_q == ST_WR_DIV && ack) begin
                div_valid_q <= 1'b1;
                div_last_q  <= cfg_div_i;
            end
            if (state_q == ST_RD_RX && ack) begin
                rsp_data_q <= wb.m_dat_i;
                rsp_id_q   <= cur_id_q;
            end
        end
    end

    // Gated by reset so a held request cannot show a grant while the FSM is held in reset.
    always_comb begin
        gnt_o = '0;
        if (state_q == ST_IDLE && found && !wb_rst_in) gnt_o[win_id] = 1'b1;
    end

    assign busy_o      = (state_q != ST_IDLE);
    assign rsp_valid_o = (state_q == ST_RESP);
    assign rsp_id_o    = rsp_id_q;
    assign rsp_data_o  = rsp_data_q;

endmodule

// File: tb/tb_spi_xfer_sched.sv
// Self-checking bench for spi_xfer_sched: table vectors, reset corner case and random batches
// against a transaction-level model, with a behavioural SPI core on the Wishbone side.
module tb_spi_xfer_sched;

`ifdef SPI_SCHED_POLL_EN
    localparam bit IE_EXP = 1'b0;
`else
    localparam bit IE_EXP = 1'b1;
`endif

    typedef struct {
        logic        we;
        logic [4:0]  adr;
        logic [31:0] dat;
    } wb_t;

    typedef struct {
        int          id;
        logic [31:0] data;
    } rsp_t;

    typedef struct {
        logic [3:0]       req;
        logic [15:0]      div;
        int               ack_dly;
        int               n_gnt;
        logic [2:0][3:0]  g;
        int               writes;
        int               stb_len;
        logic [31:0]      d0;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req;
    logic [127:0] req_tx;
    logic [27:0]  req_len;
    logic [31:0]  req_ss;
    logic [15:0]  cfg_div;
    logic [2:0]   cfg_mode;
    logic [3:0]   gnt;
    logic         busy, rsp_valid;
    logic [2:0]   rsp_id;
    logic [31:0]  rsp_data;

    spi_xfer_sched_if wbif ();

    spi_xfer_sched #(.NREQ(4), .SS_NB(8), .DIV_W(16)) dut (
        .wb_clk_in   (clk),
        .wb_rst_in   (rst),
        .req_i       (req),
        .req_tx_i    (req_tx),
        .req_len_i   (req_len),
        .req_ss_i    (req_ss),
        .cfg_div_i   (cfg_div),
        .cfg_mode_i  (cfg_mode),
        .gnt_o       (gnt),
        .busy_o      (busy),
        .rsp_valid_o (rsp_valid),
        .rsp_id_o    (rsp_id),
        .rsp_data_o  (rsp_data),
        .wb          (wbif)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Behavioural SPI core: RX0 = last TX0 ^ 0xFF, done after int_dly cycles, GO reads 1,1,0.
    int          ack_dly, int_dly;
    int          wait_cnt, int_cnt, go_reads;
    logic        int_q;
    logic [31:0] tx_reg;

    assign wbif.m_ack_i = wbif.m_stb_o && wbif.m_cyc_o && (wait_cnt == ack_dly);
    assign wbif.m_int_i = int_q;
    assign wbif.m_dat_i = (wbif.m_adr_o == 5'h00) ? (tx_reg ^ 32'hFF) :
                          (wbif.m_adr_o == 5'h10) ? ((go_reads > 0) ? 32'h100 : 32'h0) : 32'h0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= 0;
            int_cnt  <= 0;
            go_reads <= 0;
            int_q    <= 1'b0;
            tx_reg   <= '0;
        end else begin
            if (wbif.m_stb_o && !wbif.m_ack_i) wait_cnt <= wait_cnt + 1;
            else wait_cnt <= 0;
            if (wbif.m_ack_i && wbif.m_we_o && wbif.m_adr_o == 5'h00) tx_reg <= wbif.m_dat_o;
            if (wbif.m_ack_i && wbif.m_we_o && wbif.m_adr_o == 5'h10 && wbif.m_dat_o[8]) begin
                int_cnt  <= int_dly + 1;
                go_reads <= 2;
            end else if (int_cnt == 1) begin
                int_cnt <= 0;
                int_q   <= 1'b1;
            end else if (int_cnt > 1) begin
                int_cnt <= int_cnt - 1;
            end
            if (wbif.m_ack_i && !wbif.m_we_o && wbif.m_adr_o == 5'h10 && go_reads > 0)
                go_reads <= go_reads - 1;
            if (wbif.m_ack_i && !wbif.m_we_o && wbif.m_adr_o == 5'h00) int_q <= 1'b0;
        end
    end

    // Reference model state
    wb_t         exp_wb[$];
    rsp_t        exp_rsp[$];
    int          m_ptr = 0;
    bit          m_div_valid = 1'b0;
    logic [15:0] m_div_last = '0;
    logic [31:0] op_tx[4];
    logic [6:0]  op_len[4];
    logic [7:0]  op_ss[4];

    // Per-batch statistics
    logic [3:0]  b_gnt[$];
    int          b_writes, b_min_stb, b_max_stb, ctrl_seen, poll_reads;
    logic [31:0] b_d0;
    bit          b_d0_set;

    // Wishbone monitor: every completed access is checked against the model's expected list.
    initial begin
        bit  gap_chk;
        wb_t e;
        gap_chk = 1'b0;
        ctrl_seen = 0;
        poll_reads = 0;
        forever begin
            @(negedge clk);
            if (gap_chk) begin
                chk("wb_gap_after_ack", {31'd0, wbif.m_stb_o}, 32'd0);
                gap_chk = 1'b0;
            end
            if (!rst && wbif.m_stb_o && wbif.m_ack_i) begin
                bit skip;
                skip = 1'b0;
                gap_chk = 1'b1;
                if (wait_cnt + 1 < b_min_stb) b_min_stb = wait_cnt + 1;
                if (wait_cnt + 1 > b_max_stb) b_max_stb = wait_cnt + 1;
                chk("wb_cyc_sel", {27'd0, wbif.m_cyc_o, wbif.m_sel_o}, 32'h1F);
`ifdef SPI_SCHED_POLL_EN
                if (!wbif.m_we_o && wbif.m_adr_o == 5'h10) begin
                    poll_reads++;
                    skip = 1'b1;
                end
`endif
                if (!skip) begin
                    if (exp_wb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL wb_unexpected: got we=%0b adr=0x%02h dat=0x%08h, none expected",
                                 wbif.m_we_o, wbif.m_adr_o, wbif.m_dat_o);
                    end else begin
                        e = exp_wb.pop_front();
                        chk("wb_we", {31'd0, wbif.m_we_o}, {31'd0, e.we});
                        chk("wb_adr", {27'd0, wbif.m_adr_o}, {27'd0, e.adr});
                        if (e.we) chk("wb_dat", wbif.m_dat_o, e.dat);
                    end
                end
                if (wbif.m_we_o) b_writes++;
                if (wbif.m_we_o && wbif.m_adr_o == 5'h10) ctrl_seen++;
            end
        end
    end

    // Round-robin pick and expected bus transfers, computed from the current request set.
    task automatic model_grant();
        int          w, j;
        logic [31:0] ctrl;
        w = -1;
        for (int k = 0; k < 4; k++) begin
            j = (m_ptr + k) % 4;
            if (w < 0 && req[j]) w = j;
        end
        b_gnt.push_back(gnt);
        if (w < 0) begin
            chk("gnt_without_req", {28'd0, gnt}, 32'd0);
            return;
        end
        chk("gnt_winner", {28'd0, gnt}, {28'd0, 4'b0001 << w});
        m_ptr = (w + 1) % 4;
        if (!m_div_valid || cfg_div != m_div_last) begin
            exp_wb.push_back('{1'b1, 5'h14, {16'd0, cfg_div}});
            m_div_valid = 1'b1;
            m_div_last  = cfg_div;
        end
        ctrl = 32'(op_len[w]) + 32'h100 + 32'h2000 + (IE_EXP ? 32'h1000 : 32'h0) +
               (cfg_mode[0] ? 32'h200 : 32'h0) + (cfg_mode[1] ? 32'h400 : 32'h0) +
               (cfg_mode[2] ? 32'h800 : 32'h0);
        exp_wb.push_back('{1'b1, 5'h18, {24'd0, op_ss[w]}});
        exp_wb.push_back('{1'b1, 5'h00, op_tx[w]});
        exp_wb.push_back('{1'b1, 5'h10, ctrl});
        exp_wb.push_back('{1'b0, 5'h00, 32'h0});
        exp_rsp.push_back('{w, op_tx[w] ^ 32'hFF});
    endtask

    task automatic drive_ops();
        for (int i = 0; i < 4; i++) begin
            req_tx[32*i +: 32] = op_tx[i];
            req_len[7*i +: 7]  = op_len[i];
            req_ss[8*i +: 8]   = op_ss[i];
        end
    endtask

    // Raise a set of requests, each held until its grant, and run until all responses arrive.
    task automatic run_batch(input logic [3:0] mask, input logic [15:0] div, input logic [2:0] mode,
                             input int ad, input int idl, input int budget);
        logic [3:0] drop;
        int         cyc;
        bit         lat_chk;
        rsp_t       r;
        b_gnt.delete();
        b_writes = 0;
        b_min_stb = 1000;
        b_max_stb = 0;
        b_d0_set = 1'b0;
        b_d0 = '0;
        @(posedge clk);
        #1;
        drive_ops();
        cfg_div  = div;
        cfg_mode = mode;
        ack_dly  = ad;
        int_dly  = idl;
        req      = mask;
        cyc      = 0;
        lat_chk  = 1'b0;
        while ((req != 0 || exp_rsp.size() != 0) && cyc < budget) begin
            @(negedge clk);
            if (lat_chk) begin
                chk("req_to_stb_latency", {31'd0, wbif.m_stb_o}, 32'd1);
                lat_chk = 1'b0;
            end
            drop = gnt;
            if (gnt != 0) begin
                model_grant();
                lat_chk = 1'b1;
            end
            if (rsp_valid) begin
                chk("busy_in_resp", {31'd0, busy}, 32'd1);
                if (exp_rsp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: got id=%0d data=0x%08h, none expected",
                             rsp_id, rsp_data);
                end else begin
                    r = exp_rsp.pop_front();
                    chk("rsp_id", {29'd0, rsp_id}, 32'(r.id));
                    chk("rsp_data", rsp_data, r.data);
                    if (!b_d0_set) begin
                        b_d0 = rsp_data;
                        b_d0_set = 1'b1;
                    end
                end
            end
            @(posedge clk);
            #1;
            req = req & ~drop;
            cyc++;
        end
        chk("batch_within_budget", {31'd0, cyc < budget}, 32'd1);
        chk("wb_all_issued", 32'(exp_wb.size()), 32'd0);
        if (cyc >= budget) begin
            req = '0;
            exp_wb.delete();
            exp_rsp.delete();
        end
    endtask

    vec_t tbl[6];

    initial begin
        logic [15:0] div;
        int          ctrl0, n, vcnt;
        rst = 1'b1;
        req = '0;
        req_tx = '0;
        req_len = '0;
        req_ss = '0;
        cfg_div = '0;
        cfg_mode = '0;
        ack_dly = 0;
        int_dly = 2;
        b_min_stb = 1000;
        b_max_stb = 0;
        b_writes = 0;

        //            req      div     dly ngnt  grants (g[2],g[1],g[0])         wr stb d0
        tbl[0] = '{4'b0001, 16'd4, 0, 1, {4'b0000, 4'b0000, 4'b0001}, 4, 1, 32'h0000005A};
        tbl[1] = '{4'b0001, 16'd4, 0, 1, {4'b0000, 4'b0000, 4'b0001}, 3, 1, 32'h0000005A};
        tbl[2] = '{4'b0001, 16'd9, 0, 1, {4'b0000, 4'b0000, 4'b0001}, 4, 1, 32'h0000005A};
        tbl[3] = '{4'b1000, 16'd9, 3, 1, {4'b0000, 4'b0000, 4'b1000}, 3, 4, 32'h0003005A};
        tbl[4] = '{4'b0101, 16'd9, 0, 2, {4'b0000, 4'b0100, 4'b0001}, 6, 1, 32'h0000005A};
        tbl[5] = '{4'b0111, 16'd9, 0, 3, {4'b0100, 4'b0010, 4'b0001}, 9, 1, 32'h0000005A};

        for (int i = 0; i < 4; i++) begin
            op_tx[i]  = 32'h0000_00A5 | (32'(i) << 16);
            op_len[i] = 7'd8;
            op_ss[i]  = 8'(1 << i);
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        req = 4'b0001;
        #1;
        chk("gnt_held_in_reset", {28'd0, gnt}, 32'd0);
        req = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_id", {29'd0, rsp_id}, 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_bus_ctl", {28'd0, wbif.m_cyc_o, wbif.m_stb_o, wbif.m_we_o, 1'b0}, 32'd0);
        chk("rst_adr_sel", {23'd0, wbif.m_adr_o, wbif.m_sel_o}, 32'd0);
        chk("rst_dat", wbif.m_dat_o, 32'd0);

        for (int v = 0; v < 6; v++) begin
            run_batch(tbl[v].req, tbl[v].div, 3'b000, tbl[v].ack_dly, 2, 500);
            chk($sformatf("tbl%0d_ngnt", v), 32'(b_gnt.size()), 32'(tbl[v].n_gnt));
            n = (b_gnt.size() < tbl[v].n_gnt) ? b_gnt.size() : tbl[v].n_gnt;
            for (int g = 0; g < n; g++)
                chk($sformatf("tbl%0d_gnt%0d", v, g), {28'd0, b_gnt[g]}, {28'd0, tbl[v].g[g]});
            chk($sformatf("tbl%0d_writes", v), 32'(b_writes), 32'(tbl[v].writes));
            chk($sformatf("tbl%0d_stb_min", v), 32'(b_min_stb), 32'(tbl[v].stb_len));
            chk($sformatf("tbl%0d_stb_max", v), 32'(b_max_stb), 32'(tbl[v].stb_len));
            chk($sformatf("tbl%0d_rsp_data0", v), b_d0, tbl[v].d0);
        end

`ifdef SPI_SCHED_POLL_EN
        poll_reads = 0;
        run_batch(4'b0010, 16'd9, 3'b000, 0, 2, 500);
        chk("poll_ctrl_reads", 32'(poll_reads), 32'd3);
`endif

        // Reset while waiting for completion: no response, divider rewritten afterwards.
        @(posedge clk);
        #1;
        drive_ops();
        cfg_div = 16'd9;
        cfg_mode = 3'b000;
        ack_dly = 0;
        int_dly = 40;
        ctrl0 = ctrl_seen;
        req = 4'b0001;
        @(negedge clk);
        chk("rstw_gnt", {28'd0, gnt}, 32'h1);
        if (gnt != 0) model_grant();
        @(posedge clk);
        #1;
        req = '0;
        for (int c = 0; c < 100 && ctrl_seen == ctrl0; c++) @(negedge clk);
        chk("rstw_ctrl_written", 32'(ctrl_seen - ctrl0), 32'd1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstw_cyc_stb", {30'd0, wbif.m_cyc_o, wbif.m_stb_o}, 32'd0);
        chk("rstw_busy", {31'd0, busy}, 32'd0);
        chk("rstw_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        exp_wb.delete();
        exp_rsp.delete();
        m_ptr = 0;
        m_div_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        vcnt = 0;
        repeat (60) begin
            @(negedge clk);
            if (rsp_valid) vcnt++;
        end
        chk("rstw_no_rsp", 32'(vcnt), 32'd0);
        run_batch(4'b0001, 16'd9, 3'b000, 0, 2, 500);
        chk("rstw_div_rewritten", 32'(b_writes), 32'd4);

        // Random batches against the model.
        div = 16'd9;
        for (int b = 0; b < 40; b++) begin
            for (int i = 0; i < 4; i++) begin
                op_tx[i]  = $urandom;
                op_len[i] = 7'($urandom);
                op_ss[i]  = 8'($urandom);
            end
            if ($urandom_range(0, 2) == 0) div = 16'($urandom_range(1, 50));
            run_batch(4'($urandom_range(1, 15)), div, 3'($urandom), $urandom_range(0, 3),
                      $urandom_range(0, 6), 3000);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
